// File: rtl/panel_pkg.sv
// Shared types and helpers for the front-panel sequencer.
// Run/Mem FSM state encodings and debounce counter sizing.
package panel_pkg;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ISSUE,
      R_WAIT_DONE
   } run_state_t;

   typedef enum logic [1:0] {
      M_IDLE,
      M_REQ,
      M_WAIT
   } mem_state_t;

   localparam int DEBOUNCE_CYC_DEF = 16;
   localparam int DBNC_W = $clog2(DEBOUNCE_CYC_DEF + 1);

   function automatic int dbnc_w(input int cyc);
      return $clog2(cyc + 1);
   endfunction

endpackage

// File: rtl/panel_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, press pulse.
// Ports: clk, reset, i_raw (async button), o_event (1-cycle press pulse).
module panel_debounce
   import panel_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_event
);

   localparam int CNT_W = dbnc_w(DEBOUNCE_CYC);

   logic             r_s1;
   logic             r_s2;
   logic             r_stable;
   logic             r_event;
   logic [CNT_W-1:0] r_cnt;

   // r_cnt counts consecutive samples that differ from the accepted level.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_stable <= 1'b0;
         r_event  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_s1    <= i_raw;
         r_s2    <= r_s1;
         r_event <= 1'b0;
         if (r_s2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            r_stable <= r_s2;
            r_event  <= r_s2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_event = r_event;

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel sequencer: debounced commands, auto-run with breakpoint,
// manual memory read/write with timeout, register arrangement pulses.
// Ports: raw btn_*/switch_* in; panel values in; instr_done/mem_reply in;
// start/clear pulses, arr_* writes, mem_* requests, status flags out.
module panel_ctrl
   import panel_pkg::*;
#(
   parameter int WORD_W       = 31,
   parameter int ADDR_W       = 12,
   parameter int DEBOUNCE_CYC = 16,
   parameter int MEM_TIMEOUT  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_machine_start,
   input  logic              btn_clear_pulse,
   input  logic              btn_do_read_mem,
   input  logic              btn_do_write_mem,
   input  logic              btn_write_reg,
   input  logic              btn_clear_reg_c,
   input  logic              btn_clear_reg_select,
   input  logic              btn_clear_reg_start,
   input  logic              switch_auto_enable,
   input  logic              switch_stop_at_enable,
   input  logic              switch_select_or_start,
   input  logic              switch_arr_reg_c,
   input  logic              switch_arr_reg_select,
   input  logic              switch_arr_reg_start,
   input  logic [WORD_W-1:0] input_reg_c_value,
   input  logic [ADDR_W-1:0] input_reg_select_value,
   input  logic [ADDR_W-1:0] input_reg_start_value,
   input  logic [ADDR_W-1:0] reg_start_value,
   input  logic              instr_done,
   input  logic              mem_reply,
   output logic              start_pulse,
   output logic              clear_pulse,
   output logic              arr_c_valid,
   output logic [WORD_W-1:0] arr_c_data,
   output logic              arr_select_valid,
   output logic [ADDR_W-1:0] arr_select_data,
   output logic              arr_start_valid,
   output logic [ADDR_W-1:0] arr_start_data,
   output logic              mem_read_req,
   output logic              mem_write_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              running,
   output logic              stopped_at,
   output logic              mem_error
);

   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

   logic [7:0] w_btn_raw;
   logic [7:0] w_ev;
   logic [5:0] r_sw_s1;
   logic [5:0] r_sw_s2;

   assign w_btn_raw = {btn_clear_reg_start, btn_clear_reg_select,
                       btn_clear_reg_c, btn_write_reg,
                       btn_do_write_mem, btn_do_read_mem,
                       btn_clear_pulse, btn_machine_start};

   for (genvar i = 0; i < 8; i++) begin : g_dbnc
      panel_debounce #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_dbnc (
         .clk    (clk),
         .reset  (reset),
         .i_raw  (w_btn_raw[i]),
         .o_event(w_ev[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sw_s1 <= '0;
         r_sw_s2 <= '0;
      end else begin
         r_sw_s1 <= {switch_arr_reg_start, switch_arr_reg_select,
                     switch_arr_reg_c, switch_select_or_start,
                     switch_stop_at_enable, switch_auto_enable};
         r_sw_s2 <= r_sw_s1;
      end
   end

   logic w_ev_start, w_ev_clear, w_ev_rd, w_ev_wr;
   logic w_ev_wreg, w_ev_clrc, w_ev_clrsel, w_ev_clrst;
   logic w_sw_auto, w_sw_stop, w_sw_sos;
   logic w_sw_c, w_sw_sel, w_sw_st;

   assign {w_ev_clrst, w_ev_clrsel, w_ev_clrc, w_ev_wreg,
           w_ev_wr, w_ev_rd, w_ev_clear, w_ev_start} = w_ev;
   assign {w_sw_st, w_sw_sel, w_sw_c,
           w_sw_sos, w_sw_stop, w_sw_auto} = r_sw_s2;

   run_state_t r_run_st;
   mem_state_t r_mem_st;
   logic       r_start_p, r_clear_p, r_running, r_stopped;
   logic       w_bp_hit, w_run_go, w_mem_go;

   assign w_bp_hit = w_sw_stop &&
                     (reg_start_value == input_reg_select_value);
   // Run and Mem FSMs never leave IDLE together; start wins a tie.
   assign w_run_go = w_ev_start && !w_ev_clear &&
                     (r_run_st == R_IDLE) && (r_mem_st == M_IDLE);
   assign w_mem_go = (w_ev_rd || w_ev_wr) && !w_ev_start &&
                     (r_run_st == R_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_run_st  <= R_IDLE;
         r_start_p <= 1'b0;
         r_clear_p <= 1'b0;
         r_running <= 1'b0;
         r_stopped <= 1'b0;
      end else begin
         r_start_p <= 1'b0;
         r_clear_p <= w_ev_clear;
         if (w_ev_clear) begin
            r_run_st  <= R_IDLE;
            r_running <= 1'b0;
            r_stopped <= 1'b0;
         end else begin
            unique case (r_run_st)
               R_IDLE: begin
                  if (w_run_go) begin
                     r_run_st  <= R_ISSUE;
                     r_start_p <= 1'b1;
                     r_running <= 1'b1;
                     r_stopped <= 1'b0;
                  end
               end
               R_ISSUE: r_run_st <= R_WAIT_DONE;
               R_WAIT_DONE: begin
                  if (instr_done) begin
                     if (w_bp_hit) r_stopped <= 1'b1;
                     if (w_sw_auto && !w_bp_hit) begin
                        r_run_st  <= R_ISSUE;
                        r_start_p <= 1'b1;
                     end else begin
                        r_run_st  <= R_IDLE;
                        r_running <= 1'b0;
                     end
                  end
               end
               default: r_run_st <= R_IDLE;
            endcase
         end
      end
   end

   logic              r_is_rd, r_rd_req, r_wr_req, r_mem_err;
   logic [TMO_W-1:0]  r_tmo;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [WORD_W-1:0] r_mem_wdata;
   logic              r_c_vld, r_sel_vld, r_st_vld;
   logic [WORD_W-1:0] r_c_data;
   logic [ADDR_W-1:0] r_sel_data, r_st_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_st    <= M_IDLE;
         r_is_rd     <= 1'b0;
         r_rd_req    <= 1'b0;
         r_wr_req    <= 1'b0;
         r_mem_err   <= 1'b0;
         r_tmo       <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_c_vld     <= 1'b0;
         r_sel_vld   <= 1'b0;
         r_st_vld    <= 1'b0;
         r_c_data    <= '0;
         r_sel_data  <= '0;
         r_st_data   <= '0;
      end else begin
         r_rd_req  <= 1'b0;
         r_wr_req  <= 1'b0;
         r_c_vld   <= 1'b0;
         r_sel_vld <= 1'b0;
         r_st_vld  <= 1'b0;
         if (w_ev_clear) begin
            r_mem_st  <= M_IDLE;
            r_mem_err <= 1'b0;
         end else begin
            unique case (r_mem_st)
               M_IDLE: begin
                  if (r_run_st == R_IDLE) begin
                     if (w_ev_wreg && w_sw_c) begin
                        r_c_vld  <= 1'b1;
                        r_c_data <= input_reg_c_value;
                     end
                     if (w_ev_wreg && w_sw_sel) begin
                        r_sel_vld  <= 1'b1;
                        r_sel_data <= input_reg_select_value;
                     end
                     if (w_ev_wreg && w_sw_st) begin
                        r_st_vld  <= 1'b1;
                        r_st_data <= input_reg_start_value;
                     end
                     // Later assignments give the zero write priority.
                     if (w_ev_clrc) begin
                        r_c_vld  <= 1'b1;
                        r_c_data <= '0;
                     end
                     if (w_ev_clrsel) begin
                        r_sel_vld  <= 1'b1;
                        r_sel_data <= '0;
                     end
                     if (w_ev_clrst) begin
                        r_st_vld  <= 1'b1;
                        r_st_data <= '0;
                     end
                  end
                  if (w_mem_go) begin
                     r_mem_st    <= M_REQ;
                     r_is_rd     <= w_ev_rd;
                     r_rd_req    <= w_ev_rd;
                     r_wr_req    <= !w_ev_rd;
                     r_mem_wdata <= input_reg_c_value;
                     r_mem_addr  <= w_sw_sos ? input_reg_select_value
                                             : input_reg_start_value;
                  end
               end
               M_REQ: begin
                  r_mem_st <= M_WAIT;
                  r_tmo    <= '0;
               end
               M_WAIT: begin
                  if (mem_reply) begin
                     r_mem_st <= M_IDLE;
                     // C is loaded by the core; zero data marks the slot.
                     if (r_is_rd) begin
                        r_c_vld  <= 1'b1;
                        r_c_data <= '0;
                     end
                  end else if (r_tmo == TMO_W'(MEM_TIMEOUT - 1)) begin
                     r_mem_err <= 1'b1;
                     r_mem_st  <= M_IDLE;
                  end else begin
                     r_tmo <= r_tmo + 1'b1;
                  end
               end
               default: r_mem_st <= M_IDLE;
            endcase
         end
      end
   end

   assign start_pulse      = r_start_p;
   assign clear_pulse      = r_clear_p;
   assign running          = r_running;
   assign stopped_at       = r_stopped;
   assign mem_error        = r_mem_err;
   assign mem_read_req     = r_rd_req;
   assign mem_write_req    = r_wr_req;
   assign mem_addr         = r_mem_addr;
   assign mem_wdata        = r_mem_wdata;
   assign arr_c_valid      = r_c_vld;
   assign arr_c_data       = r_c_data;
   assign arr_select_valid = r_sel_vld;
   assign arr_select_data  = r_sel_data;
   assign arr_start_valid  = r_st_vld;
   assign arr_start_data   = r_st_data;

endmodule

// File: tb/tb_panel_ctrl.sv
// Directed bench for panel_ctrl: debounce, auto-run breakpoint,
// memory handshake and timeout, register arrangement, clear.
module tb_panel_ctrl;

   localparam int WW  = 31;
   localparam int AW  = 12;
   localparam int DBN = 16;
   localparam int TMO = 64;

   localparam int B_START = 0;
   localparam int B_CLR   = 1;
   localparam int B_RD    = 2;
   localparam int B_WR    = 3;
   localparam int B_WREG  = 4;
   localparam int B_CLRC  = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    btn = '0;
   logic          sw_auto = 0, sw_stop = 0, sw_sos = 0;
   logic          sw_c = 0, sw_sel = 0, sw_st = 0;
   logic [WW-1:0] in_c = '0;
   logic [AW-1:0] in_sel = '0, in_st = '0, reg_start = '0;
   logic          instr_done = 0, mem_reply = 0;

   logic          start_pulse, clear_pulse, running, stopped_at;
   logic          mem_error, mem_read_req, mem_write_req;
   logic          arr_c_valid, arr_select_valid, arr_start_valid;
   logic [WW-1:0] arr_c_data, mem_wdata;
   logic [AW-1:0] arr_select_data, arr_start_data, mem_addr;

   panel_ctrl #(
      .WORD_W(WW), .ADDR_W(AW),
      .DEBOUNCE_CYC(DBN), .MEM_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .btn_machine_start(btn[0]), .btn_clear_pulse(btn[1]),
      .btn_do_read_mem(btn[2]), .btn_do_write_mem(btn[3]),
      .btn_write_reg(btn[4]), .btn_clear_reg_c(btn[5]),
      .btn_clear_reg_select(btn[6]), .btn_clear_reg_start(btn[7]),
      .switch_auto_enable(sw_auto), .switch_stop_at_enable(sw_stop),
      .switch_select_or_start(sw_sos), .switch_arr_reg_c(sw_c),
      .switch_arr_reg_select(sw_sel), .switch_arr_reg_start(sw_st),
      .input_reg_c_value(in_c), .input_reg_select_value(in_sel),
      .input_reg_start_value(in_st), .reg_start_value(reg_start),
      .instr_done(instr_done), .mem_reply(mem_reply),
      .start_pulse(start_pulse), .clear_pulse(clear_pulse),
      .arr_c_valid(arr_c_valid), .arr_c_data(arr_c_data),
      .arr_select_valid(arr_select_valid),
      .arr_select_data(arr_select_data),
      .arr_start_valid(arr_start_valid),
      .arr_start_data(arr_start_data),
      .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .running(running), .stopped_at(stopped_at),
      .mem_error(mem_error)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   int n_clr = 0, n_c = 0, n_sel = 0, n_st = 0, n_rd = 0, n_wr = 0;
   logic [WW-1:0] last_c = '0;
   logic [AW-1:0] last_sel = '0;

   always @(negedge clk) begin
      if (clear_pulse) n_clr++;
      if (arr_c_valid) begin n_c++; last_c = arr_c_data; end
      if (arr_select_valid) begin n_sel++; last_sel = arr_select_data; end
      if (arr_start_valid) n_st++;
      if (mem_read_req) n_rd++;
      if (mem_write_req) n_wr++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] mask);
      btn = btn | mask;
      step(DBN + 5);
      btn = btn & ~mask;
      step(DBN + 10);
   endtask

   int c0, c1, c2, c3, pulses, first, dly, rq, err_c, req_c;
   logic [AW-1:0] a;
   logic [WW-1:0] wd;
   logic seen, run_at;

   initial begin
      step(3);
      check("rst_flags",
            {22'd0, start_pulse, clear_pulse, arr_c_valid,
             arr_select_valid, arr_start_valid, mem_read_req,
             mem_write_req, running, stopped_at, mem_error}, 0);
      check("rst_addr", {20'd0, mem_addr}, 0);
      check("rst_cdata", {1'b0, arr_c_data}, 0);
      reset = 0;
      step(2);

      // Single start, auto off
      pulses = 0; first = 0;
      btn[B_START] = 1;
      for (int c = 1; c <= 40; c++) begin
         step(1);
         if (c == DBN + 5) btn[B_START] = 0;
         if (start_pulse) begin
            pulses++;
            if (first == 0) first = c;
         end
      end
      check("t1_pulses", pulses, 1);
      check("t1_latency", first, DBN + 3);
      check("t1_running", {31'd0, running}, 1);
      instr_done = 1; step(1); instr_done = 0;
      check("t1_idle", {31'd0, running}, 0);

      // Short glitch on write_reg
      sw_c = 1; sw_sel = 1; sw_st = 1;
      c0 = n_c + n_sel + n_st;
      btn[B_WREG] = 1; step(3); btn[B_WREG] = 0;
      step(40);
      check("t2_glitch", n_c + n_sel + n_st - c0, 0);

      // Plain arrangement write
      sw_st = 0; in_c = 31'h12345678; in_sel = 12'h0A3;
      in_st = 12'h011;
      c0 = n_c; c1 = n_sel; c2 = n_st;
      press(8'h1 << B_WREG);
      check("t6_c_cnt", n_c - c0, 1);
      check("t6_c_data", {1'b0, last_c}, 32'h12345678);
      check("t6_sel_cnt", n_sel - c1, 1);
      check("t6_sel_data", {20'd0, last_sel}, 32'h0A3);
      check("t6_st_cnt", n_st - c2, 0);

      // clear_reg_c and write_reg together: zero wins
      c0 = n_c;
      press((8'h1 << B_WREG) | (8'h1 << B_CLRC));
      check("t6_tie_cnt", n_c - c0, 1);
      check("t6_tie_data", {1'b0, last_c}, 0);
      press(8'h1 << B_WREG);
      check("t6_reload", {1'b0, last_c}, 32'h12345678);

      // Auto-run to breakpoint
      sw_c = 0; sw_sel = 0;
      sw_auto = 1; sw_stop = 1; in_sel = 12'h005;
      reg_start = 12'h002;
      step(3);
      pulses = 0; dly = 0;
      btn[B_START] = 1;
      for (int c = 1; c <= 120; c++) begin
         step(1);
         if (c == DBN + 5) btn[B_START] = 0;
         if (instr_done) begin
            instr_done = 0;
            reg_start = reg_start + 1'b1;
         end
         if (start_pulse) begin
            pulses++;
            dly = 3;
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) instr_done = 1;
         end
      end
      check("t3_pulses", pulses, 4);
      check("t3_stopped", {31'd0, stopped_at}, 1);
      check("t3_running", {31'd0, running}, 0);

      // Manual read with reply
      sw_auto = 0; sw_stop = 0; sw_sos = 1; in_sel = 12'h0A3;
      step(3);
      c0 = n_c; c1 = n_wr;
      rq = 0; dly = 0; a = '0;
      btn[B_RD] = 1;
      for (int c = 1; c <= 60; c++) begin
         step(1);
         if (c == DBN + 5) btn[B_RD] = 0;
         if (mem_reply) mem_reply = 0;
         if (mem_read_req) begin
            rq++;
            a = mem_addr;
            dly = 4;
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) mem_reply = 1;
         end
      end
      check("t4_rd_cnt", rq, 1);
      check("t4_addr", {20'd0, a}, 32'h0A3);
      check("t4_c_cnt", n_c - c0, 1);
      check("t4_c_zero", {1'b0, last_c}, 0);
      check("t4_no_wr", n_wr - c1, 0);
      check("t4_no_err", {31'd0, mem_error}, 0);

      // Manual write with no reply -> timeout
      sw_sos = 0; in_c = 31'h0ABCDEF;
      step(3);
      rq = 0; req_c = 0; err_c = 0; a = '0; wd = '0;
      btn[B_WR] = 1;
      for (int c = 1; c <= 120; c++) begin
         step(1);
         if (c == DBN + 5) btn[B_WR] = 0;
         if (mem_write_req) begin
            rq++;
            req_c = c;
            a = mem_addr;
            wd = mem_wdata;
         end
         if (mem_error && err_c == 0) err_c = c;
      end
      check("t5_wr_cnt", rq, 1);
      check("t5_addr", {20'd0, a}, 32'h011);
      check("t5_wdata", {1'b0, wd}, 32'h0ABCDEF);
      check("t5_err", {31'd0, mem_error}, 1);
      check("t5_err_time", err_c - req_c, TMO + 1);
      c0 = n_clr;
      press(8'h1 << B_CLR);
      check("t5_clr_cnt", n_clr - c0, 1);
      check("t5_err_clr", {31'd0, mem_error}, 0);

      // Clear during WAIT_DONE
      seen = 0;
      btn[B_START] = 1;
      for (int c = 1; c <= 40; c++) begin
         step(1);
         if (c == DBN + 5) btn[B_START] = 0;
         if (start_pulse) seen = 1;
      end
      check("t7_started", {31'd0, seen}, 1);
      check("t7_waiting", {31'd0, running}, 1);
      seen = 0; run_at = 1;
      btn[B_CLR] = 1;
      for (int c = 1; c <= 40; c++) begin
         step(1);
         if (c == DBN + 5) btn[B_CLR] = 0;
         if (clear_pulse && !seen) begin
            seen = 1;
            run_at = running;
         end
      end
      check("t7_clear", {31'd0, seen}, 1);
      check("t7_run_off", {31'd0, run_at}, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/panel_ctrl.md
Name: panel_ctrl

Overview:
- Front-panel sequencer for the word-serial core. Turns raw buttons and switches into clean single-cycle command pulses to the pulse unit, memory, and the C/select/start registers.
- Adds three things the core lacks: debounce, auto-run with stop-at-address breakpoint, and a manual memory read/write handshake with timeout.
- Sits between board I/O and the core top level. Word and address widths are parametrised.

Parameters:
- WORD_W, 31, data word width including sign bit.
- ADDR_W, 12, memory/start/select address width.
- DEBOUNCE_CYC, 16, stable cycles required before a button edge is accepted (>=2).
- MEM_TIMEOUT, 64, cycles to wait for mem_reply before flagging an error (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_machine_start, btn_clear_pulse, btn_do_read_mem, btn_do_write_mem  in  1 each  raw buttons
- btn_write_reg, btn_clear_reg_c, btn_clear_reg_select, btn_clear_reg_start  in  1 each  raw buttons
- switch_auto_enable, switch_stop_at_enable, switch_select_or_start  in  1 each  raw switches
- switch_arr_reg_c, switch_arr_reg_select, switch_arr_reg_start  in  1 each  raw switches
- input_reg_c_value  in  WORD_W  panel word; also the manual memory write data
- input_reg_select_value  in  ADDR_W  panel address; also the stop-at address
- input_reg_start_value  in  ADDR_W  panel start address
- reg_start_value  in  ADDR_W  live start register
- instr_done  in  1  1-cycle pulse at the end of each instruction
- mem_reply  in  1  memory finish pulse
- start_pulse  out  1  launches one instruction
- clear_pulse  out  1  aborts the pulse unit
- arr_c_valid  out  1;  arr_c_data  out  WORD_W
- arr_select_valid  out  1;  arr_select_data  out  ADDR_W
- arr_start_valid  out  1;  arr_start_data  out  ADDR_W
- mem_read_req, mem_write_req  out  1 each  1-cycle memory requests
- mem_addr  out  ADDR_W;  mem_wdata  out  WORD_W
- running  out  1;  stopped_at  out  1;  mem_error  out  1

Behaviour:
- Reset: every output is 0; both FSMs go to IDLE; debounce counters clear.
- Inputs: every button and switch passes through a 2-FF synchroniser.
- Debounce: a button's state is accepted after DEBOUNCE_CYC consecutive equal samples. A press event is a 1-cycle pulse on the accepted 0->1 edge; release generates nothing.
  - Latency from a raw stable edge to the event is 2 + DEBOUNCE_CYC cycles.
  - Glitches shorter than DEBOUNCE_CYC produce no event.
- Run FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE + start event: go to ISSUE.
  - ISSUE: start_pulse=1 for one cycle, then WAIT_DONE.
  - WAIT_DONE + instr_done: go to ISSUE if switch_auto_enable=1 and the breakpoint does not hit; otherwise go to IDLE.
  - Breakpoint hit: switch_stop_at_enable=1 and reg_start_value == input_reg_select_value, sampled in the instr_done cycle. On a hit, stopped_at=1 until the next start event or reset.
  - running=1 in ISSUE and WAIT_DONE.
  - Clearing switch_auto_enable mid-run lets the current instruction finish, then the FSM returns to IDLE.
- Clear event, any state: clear_pulse=1 for one cycle, Run FSM to IDLE, Mem FSM to IDLE; stopped_at and mem_error clear. Clear has priority over every other event in the same cycle.
- Register arrangement, accepted only when both FSMs are IDLE (ignored otherwise):
  - Write_reg event: for each set switch_arr_reg_x, arr_x_valid=1 for one cycle with the matching input value.
  - btn_clear_reg_x event: arr_x_valid=1 with zero data.
  - Clear_reg and write_reg for the same register in the same cycle: the zero write wins.
- Mem FSM states: IDLE, REQ, WAIT.
  - Read or write event, only when the Run FSM is IDLE: go to REQ and latch mem_addr. mem_addr is input_reg_select_value if switch_select_or_start=1, else input_reg_start_value; mem_wdata is input_reg_c_value.
  - REQ: exactly one cycle of mem_read_req or mem_write_req, then WAIT.
  - Read and write events in the same cycle: read wins.
  - WAIT + mem_reply: go to IDLE. A read also drives arr_c_valid=1 for one cycle, arr_c_data=0; the C register is loaded by the core from memory.
  - WAIT for MEM_TIMEOUT cycles without mem_reply: set mem_error and go to IDLE. mem_error is sticky until clear or reset.
  - A start event while the Mem FSM is busy is dropped.
- Reset asserted mid-operation: all state returns to reset values on the next clock edge, with no trailing pulses.

Decomposition:
- panel_pkg holds the run_state_t and mem_state_t enums and the DBNC_W = $clog2(DEBOUNCE_CYC+1) constant.
- One sub-module, panel_debounce (synchroniser + counter + edge pulse), instantiated once per button. The same synchroniser is reused for the switches.

Test Plan:
- Raw btn_machine_start held 1 for DEBOUNCE_CYC+5 cycles with auto=0 -> exactly one start_pulse at cycle 2+DEBOUNCE_CYC+1; after instr_done, running returns to 0.
- 3-cycle glitch on btn_write_reg -> no arr_*_valid.
- auto=1, stop_at=1, select=0x005, reg_start_value stepping 0x002..0x005 at each instr_done -> 3 start_pulses after the first; stopped_at=1 once start is 0x005.
- switch_select_or_start=1, select=0x0A3, read event, mem_reply 4 cycles after the request -> mem_addr=0x0A3; one mem_read_req; arr_c_valid pulse on reply.
- Write event with no mem_reply -> mem_write_req once; mem_error=1 after MEM_TIMEOUT cycles; next clear event -> mem_error=0.
- switch_arr_reg_c=1, input_reg_c_value=0x12345678, clear_reg_c and write_reg events in the same cycle -> arr_c_valid=1 with data 0. Clear event during WAIT_DONE -> clear_pulse and running=0 the next cycle.
